// File: rtl/mock_alu_pkg.sv
// Shared opcode type and opcode constants for the mock ALU pipeline.
package mock_alu_pkg;

  localparam int OP_W = 6;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 6'd0;
  localparam alu_op_t OP_SUB  = 6'd1;
  localparam alu_op_t OP_AND  = 6'd2;
  localparam alu_op_t OP_OR   = 6'd3;
  localparam alu_op_t OP_XOR  = 6'd4;
  localparam alu_op_t OP_SLL  = 6'd5;
  localparam alu_op_t OP_SRL  = 6'd6;
  localparam alu_op_t OP_SRA  = 6'd7;
  localparam alu_op_t OP_SLT  = 6'd8;
  localparam alu_op_t OP_SLTU = 6'd9;

endpackage

// File: rtl/mock_alu_core.sv
// Purely combinational ALU core; undefined opcodes give result 0 and illegal=1.
module mock_alu_core
  import mock_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  // Only the low bits of b select the shift distance.
  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_op_t'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $signed(a) >>> shamt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mock_alu_pipe.sv
// Elastic ALU pipeline: stage 0 holds operands, stages 1..STAGES-1 hold the
// result and illegal flag; every stage has its own valid bit.
module mock_alu_pipe
  import mock_alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_illegal,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and in_ready depends only on
  // out_ready and the stage valid bits, never on in_valid.

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;
  logic              load_acc;

  logic [OP_W-1:0]   op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q [1:STAGES-1];
  logic [STAGES-1:1] ill_q;

  logic [WIDTH-1:0]  core_res;
  logic              core_ill;

  mock_alu_core #(.WIDTH(WIDTH)) u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .result  (core_res),
    .illegal (core_ill)
  );

  // A stage loads if it, or any stage downstream of it, is empty, or the
  // consumer is taking the output: this is what lets bubbles collapse.
  always_comb begin
    load_acc = out_ready;
    load     = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load_acc = load_acc | ~valid[i];
      load[i]  = load_acc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ill_q <= '0;
      for (int i = 1; i < STAGES; i++) res_q[i] <= '0;
    end else begin
      if (load[0]) begin
        valid[0] <= in_valid;
        op_q     <= in_op;
        a_q      <= in_a;
        b_q      <= in_b;
      end
      if (load[1]) begin
        valid[1] <= valid[0];
        res_q[1] <= core_res;
        ill_q[1] <= core_ill;
      end
      for (int i = 2; i < STAGES; i++) begin
        if (load[i]) begin
          valid[i] <= valid[i-1];
          res_q[i] <= res_q[i-1];
          ill_q[i] <= ill_q[i-1];
        end
      end
    end
  end

  assign in_ready    = load[0];
  assign out_valid   = valid[STAGES-1];
  assign out_data    = res_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];
  assign busy        = |valid;

endmodule
